// File: rtl/ram_access_arbiter.sv
// Arbitrates CPU and AUX requesters onto a single-port RAM, one transaction in flight at a time.
// Build option RAM_ARB_RR_EN: round-robin on conflict; otherwise CPU has fixed priority.
module ram_access_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              aux_req,
  input  logic              aux_rw,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic [DATA_W-1:0] aux_rdata,
  output logic              aux_ack,
  output logic              ram_en,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t     state;
  logic       gnt_aux;
  logic       last_grant;   // 1 = AUX
  logic       lat_rw;
  logic [1:0] cnt;
  logic       pick_aux;
  req_t       win;

  always_comb begin
`ifdef RAM_ARB_RR_EN
    pick_aux = aux_req & (~cpu_req | ~last_grant);
`else
    pick_aux = aux_req & ~cpu_req;
`endif
    win = pick_aux ? req_t'{aux_rw, aux_addr, aux_wdata}
                   : req_t'{cpu_rw, cpu_addr, cpu_wdata};
  end

  // Outputs are registered alongside the state so they line up with it cycle for cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      gnt_aux    <= 1'b0;
      last_grant <= 1'b1;
      lat_rw     <= 1'b1;
      cnt        <= '0;
      ram_en     <= 1'b0;
      ram_rw     <= 1'b1;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      cpu_ack    <= 1'b0;
      aux_ack    <= 1'b0;
      cpu_rdata  <= '0;
      aux_rdata  <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req | aux_req) begin
            gnt_aux   <= pick_aux;
            lat_rw    <= win.rw;
            ram_en    <= 1'b1;
            ram_rw    <= win.rw;
            ram_addr  <= win.addr;
            ram_wdata <= win.wdata;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          ram_en <= 1'b0;
          ram_rw <= 1'b1;
          if (lat_rw) begin
            cnt   <= 2'(RD_LAT - 1);
            state <= WAIT;
          end else begin
            cpu_ack <= ~gnt_aux;
            aux_ack <= gnt_aux;
            state   <= DONE;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            if (gnt_aux) aux_rdata <= ram_rdata;
            else         cpu_rdata <= ram_rdata;
            cpu_ack <= ~gnt_aux;
            aux_ack <= gnt_aux;
            state   <= DONE;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        DONE: begin
          cpu_ack    <= 1'b0;
          aux_ack    <= 1'b0;
          last_grant <= gnt_aux;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Randomized scoreboard bench for ram_access_arbiter: a transaction-level model predicts grant
// order and read data; a monitor checks RAM strobes, ack latency and rdata as they appear.
module tb_ram_access_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RD_LAT = 3;

  logic clk, reset_n;
  logic cpu_req, cpu_rw, aux_req, aux_rw;
  logic [AW-1:0] cpu_addr, aux_addr, ram_addr;
  logic [DW-1:0] cpu_wdata, aux_wdata, cpu_rdata, aux_rdata, ram_wdata, ram_rdata;
  logic cpu_ack, aux_ack, ram_en, ram_rw, busy;

  ram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .aux_req(aux_req), .aux_rw(aux_rw), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_rdata(aux_rdata), .aux_ack(aux_ack),
    .ram_en(ram_en), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: read data appears RD_LAT cycles after ram_en; garbage otherwise
  logic          ram_clr;
  logic [DW-1:0] ram_mem [32];
  logic [DW-1:0] rpipe [RD_LAT];
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 32; i++) ram_mem[i] <= '0;
    end else if (ram_en && !ram_rw) begin
      ram_mem[ram_addr[4:0]] <= ram_wdata;
    end
    rpipe[0] <= (ram_en && ram_rw) ? ram_mem[ram_addr[4:0]] : DW'($urandom);
    for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign ram_rdata = rpipe[RD_LAT-1];

  typedef struct {
    bit            aux;
    bit            rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } txn_t;

  txn_t exp_issue[$], exp_ack[$], cpu_drv[$], aux_drv[$];
  int   issue_cyc[$];
  logic [DW-1:0] mdl_mem [32];
  bit   mdl_last_aux;
  int   nvec = 0, nfail = 0, cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic txn_t mk(input bit aux, input bit rw, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata);
    txn_t t;
    t.aux = aux; t.rw = rw; t.addr = addr; t.wdata = wdata; t.rdata = '0;
    return t;
  endfunction

  function automatic txn_t rnd(input bit aux);
    return mk(aux, bit'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom));
  endfunction

  // Reference: walk both request lists in grant order and apply each access to a model memory
  task automatic predict();
    txn_t c[$], a[$], t;
    bit w;
    c = cpu_drv; a = aux_drv;
    while (c.size() != 0 || a.size() != 0) begin
      if (c.size() != 0 && a.size() != 0) begin
`ifdef RAM_ARB_RR_EN
        w = !mdl_last_aux;
`else
        w = 1'b0;
`endif
      end else begin
        w = (a.size() != 0);
      end
      t = w ? a.pop_front() : c.pop_front();
      if (t.rw) t.rdata = mdl_mem[t.addr[4:0]];
      else      mdl_mem[t.addr[4:0]] = t.wdata;
      mdl_last_aux = w;
      exp_issue.push_back(t);
      exp_ack.push_back(t);
    end
  endtask

  task automatic wait_ack(input bit aux);
    int n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (aux ? aux_ack : cpu_ack) break;
      if (n >= 200) begin
        nvec++; nfail++;
        $display("FAIL ack_timeout: port %0d got no ack within 200 cycles", aux);
        break;
      end
    end
  endtask

  task automatic run_batch(input bit drop_aux);
    predict();
    @(negedge clk);
    fork
      begin
        txn_t t;
        while (cpu_drv.size() != 0) begin
          t = cpu_drv[0];
          cpu_rw = t.rw; cpu_addr = t.addr; cpu_wdata = t.wdata; cpu_req = 1'b1;
          wait_ack(1'b0);
          void'(cpu_drv.pop_front());
        end
        cpu_req = 1'b0;
      end
      begin
        txn_t t;
        int   n;
        while (aux_drv.size() != 0) begin
          t = aux_drv[0];
          aux_rw = t.rw; aux_addr = t.addr; aux_wdata = t.wdata; aux_req = 1'b1;
          if (drop_aux) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!ram_en && n < 50);
            aux_req = 1'b0;
            if (!aux_ack) wait_ack(1'b1);
          end else begin
            wait_ack(1'b1);
          end
          void'(aux_drv.pop_front());
        end
        aux_req = 1'b0;
      end
    join
    repeat ($urandom_range(1, 4)) @(negedge clk);
  endtask

  // Monitor / scoreboard
  logic [DW-1:0] sh_c, sh_a;
  bit prev_en, prev_ack, b2b;
  int last_ack_cyc;
  initial begin
    txn_t t;
    int   ic;
    sh_c = '0; sh_a = '0; prev_en = 0; prev_ack = 0; b2b = 0; last_ack_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        sh_c = '0; sh_a = '0; prev_en = 0; prev_ack = 0; b2b = 0;
      end else begin
        if (prev_ack) check("busy_gap_after_ack", busy, 1'b0);
        if (ram_en) begin
          check("ram_en_back_to_back", prev_en, 1'b0);
          check("busy_at_issue", busy, 1'b1);
          if (b2b) check("b2b_issue_gap", cyc - last_ack_cyc, 2);
          b2b = 0;
          if (exp_issue.size() == 0) begin
            nvec++; nfail++;
            $display("FAIL unexpected_ram_en: addr %0h", ram_addr);
          end else begin
            t = exp_issue.pop_front();
            check("ram_rw", ram_rw, t.rw);
            check("ram_addr", ram_addr, t.addr);
            if (!t.rw) check("ram_wdata", ram_wdata, t.wdata);
            issue_cyc.push_back(cyc);
          end
        end else if (ram_rw !== 1'b1) begin
          check("ram_rw_idle", ram_rw, 1'b1);
        end
        if (cpu_ack || aux_ack) begin
          check("single_ack", cpu_ack & aux_ack, 1'b0);
          check("busy_at_ack", busy, 1'b1);
          if (exp_ack.size() == 0) begin
            nvec++; nfail++;
            $display("FAIL unexpected_ack: cpu %0d aux %0d", cpu_ack, aux_ack);
          end else begin
            t  = exp_ack.pop_front();
            ic = (issue_cyc.size() != 0) ? issue_cyc.pop_front() : 0;
            check("ack_port", aux_ack, t.aux);
            check("ack_latency", cyc - ic, t.rw ? 1 + RD_LAT : 1);
            if (t.rw) begin
              if (t.aux) sh_a = t.rdata;
              else       sh_c = t.rdata;
            end
            check("cpu_rdata", cpu_rdata, sh_c);
            check("aux_rdata", aux_rdata, sh_a);
          end
          last_ack_cyc = cyc;
          b2b = (exp_issue.size() != 0);
        end
        prev_en  = ram_en;
        prev_ack = cpu_ack | aux_ack;
      end
    end
  end

  initial begin
    int n;
    reset_n = 1'b0; ram_clr = 1'b1;
    cpu_req = 0; cpu_rw = 1; cpu_addr = '0; cpu_wdata = '0;
    aux_req = 0; aux_rw = 1; aux_addr = '0; aux_wdata = '0;
    for (int i = 0; i < 32; i++) mdl_mem[i] = '0;
    mdl_last_aux = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ram_en", ram_en, 1'b0);
    check("rst_ram_rw", ram_rw, 1'b1);
    check("rst_ram_addr", ram_addr, '0);
    check("rst_ram_wdata", ram_wdata, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_acks", {cpu_ack, aux_ack}, 2'b00);
    check("rst_rdata", {cpu_rdata, aux_rdata}, '0);
    ram_clr = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // single write, then read back
    cpu_drv.push_back(mk(0, 0, 32'h10, 32'hDEADBEEF)); run_batch(0);
    cpu_drv.push_back(mk(0, 1, 32'h10, '0));           run_batch(0);
    // simultaneous requests, CPU held for three transactions
    for (int i = 0; i < 3; i++) cpu_drv.push_back(rnd(0));
    aux_drv.push_back(rnd(1)); aux_drv.push_back(rnd(1));
    run_batch(0);
    // AUX write with req dropped after grant
    aux_drv.push_back(mk(1, 0, 32'h5, 32'hA5A5_0005)); run_batch(1);
    aux_drv.push_back(mk(1, 1, 32'h5, '0));            run_batch(0);

    // reset asserted while a CPU read waits on the RAM
    @(negedge clk);
    exp_issue.push_back(mk(0, 1, 32'h10, '0));
    cpu_rw = 1; cpu_addr = 32'h10; cpu_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!ram_en && n < 50);
    @(negedge clk);
    #2 reset_n = 1'b0; cpu_req = 1'b0;
    #1;
    check("midrst_ram_en", ram_en, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_cpu_ack", cpu_ack, 1'b0);
    check("midrst_cpu_rdata", cpu_rdata, '0);
    check("midrst_aux_rdata", aux_rdata, '0);
    repeat (3) @(negedge clk);
    issue_cyc.delete();
    exp_issue.delete();
    mdl_last_aux = 1'b1;
    #2 reset_n = 1'b1;
    cpu_drv.push_back(mk(0, 1, 32'h10, '0)); run_batch(0);

    // AUX read and CPU write together
    aux_drv.push_back(mk(1, 1, 32'h10, '0));
    cpu_drv.push_back(mk(0, 0, 32'h3, 32'h1234_5678));
    run_batch(0);

    // randomized batches
    for (int b = 0; b < 30; b++) begin
      int nc, na;
      nc = $urandom_range(0, 4);
      na = $urandom_range(0, 4);
      if (nc == 0 && na == 0) nc = 1;
      for (int i = 0; i < nc; i++) cpu_drv.push_back(rnd(0));
      for (int i = 0; i < na; i++) aux_drv.push_back(rnd(1));
      run_batch(0);
    end

    n = 0;
    while (exp_ack.size() != 0 && n < 200) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    check("pending_acks", exp_ack.size(), 0);
    check("pending_issues", exp_issue.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
